// File: rtl/a0_capture_pkg.sv
// Shared types and constants for the a0 capture block.
package a0_capture_pkg;

    localparam int unsigned SEQ_W         = 16;
    localparam int unsigned DROP_W        = 8;
    localparam int unsigned DEFAULT_WIDTH = 32;

    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Entry layout at the default data width; the top re-declares it at its own WIDTH.
    typedef struct packed {
        logic [SEQ_W-1:0]         seq;
        logic [DEFAULT_WIDTH-1:0] data;
    } a0_entry_t;

    // Saturating increment for the drop counter.
    function automatic logic [DROP_W-1:0] drop_inc(input logic [DROP_W-1:0] v);
        return (v == DROP_MAX) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/a0_capture_if.sv
// Capture-side and consumer-side signals of a0_capture.
interface a0_capture_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
);
    import a0_capture_pkg::*;

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]  a0_in;
    logic              en;
    logic              clr;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [SEQ_W-1:0]  out_seq;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    modport master (
        output a0_in, en, clr, out_ready,
        input  out_valid, out_data, out_seq, level, overflow, drop_cnt
    );

    modport slave (
        input  a0_in, en, clr, out_ready,
        output out_valid, out_data, out_seq, level, overflow, drop_cnt
    );

endinterface

// File: rtl/a0_capture_sync_fifo.sv
// Synchronous FIFO with registered head, valid and level; flush beats push/pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push;
    logic             do_pop;

    // Pointer/level update and head prefetch for the next cycle.
    always_comb begin
        full     = (level_q == LVL_W'(DEPTH));
        empty    = (level_q == '0);
        do_pop   = pop && valid_q;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
        valid_d = (level_d != '0);
        head_d  = valid_d ? mem_d[rd_ptr_d] : '0;
    end

    // State registers; storage is cleared on reset so an empty head reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
        end
    end

    assign rdata = head_q;
    assign valid = valid_q;
    assign level = level_q;

endmodule

// File: rtl/a0_capture.sv
// Captures every change of a0 into a sequence-numbered FIFO with drop accounting.
module a0_capture
    import a0_capture_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 8,
    parameter bit          STOP_ON_FULL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    a0_capture_if.slave  bus
);

    localparam int unsigned ENTRY_W = SEQ_W + WIDTH;
    localparam int unsigned LVL_W   = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic [WIDTH-1:0] data;
    } entry_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  prev_q, prev_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic              change;
    logic              req;
    logic              pop;
    logic              accept;
    logic              reject;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_valid;
    entry_t            wr_entry;
    entry_t            head;
    logic [LVL_W-1:0]  fifo_level;

    // Change detection, capture arbitration, counters and FSM next state.
    always_comb begin
        change   = (bus.a0_in != prev_q);
        req      = (state_q == RUN) && change && !bus.clr;
        pop      = bus.out_ready && !fifo_empty && !bus.clr;
        accept   = req && (!fifo_full || pop);
        reject   = req && !accept;
        wr_entry = '{seq: seq_q, data: bus.a0_in};

        prev_d  = bus.a0_in;
        seq_d   = accept ? seq_q + SEQ_W'(1) : seq_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;
        state_d = state_q;

        if (reject) begin
            ovf_d  = 1'b1;
            drop_d = drop_inc(drop_q);
        end

        case (state_q)
            IDLE: if (bus.en) state_d = RUN;
            RUN: begin
                if (STOP_ON_FULL && reject) state_d = HALT;
                else if (!bus.en)           state_d = IDLE;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase

        if (bus.clr) begin
            ovf_d   = 1'b0;
            drop_d  = '0;
            state_d = IDLE;
        end
    end

    // Control state registers; clr never touches prev or the sequence counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prev_q  <= '0;
            seq_q   <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            seq_q   <= seq_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.clr),
        .push  (accept),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head),
        .valid (fifo_valid),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign bus.out_valid = fifo_valid;
    assign bus.out_data  = head.data;
    assign bus.out_seq   = head.seq;
    assign bus.level     = fifo_level;
    assign bus.overflow  = ovf_q;
    assign bus.drop_cnt  = drop_q;

endmodule

// File: tb/tb_a0_capture.sv
// Directed bench for a0_capture: one free-running and one stop-on-full instance.
module tb_a0_capture;
    import a0_capture_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    a0_capture_if #(.WIDTH(32), .DEPTH(8)) i0 ();
    a0_capture_if #(.WIDTH(32), .DEPTH(8)) i1 ();

    a0_capture #(.WIDTH(32), .DEPTH(8), .STOP_ON_FULL(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (i0)
    );

    a0_capture #(.WIDTH(32), .DEPTH(8), .STOP_ON_FULL(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (i1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        i0.a0_in = '0; i0.en = 1'b0; i0.clr = 1'b0; i0.out_ready = 1'b0;
        i1.a0_in = '0; i1.en = 1'b0; i1.clr = 1'b0; i1.out_ready = 1'b0;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        check_eq("rst_valid", 32'(i0.out_valid), 32'd0);
        check_eq("rst_level", 32'(i0.level), 32'd0);
        check_eq("rst_data", i0.out_data, 32'd0);
        check_eq("rst_seq", 32'(i0.out_seq), 32'd0);
        check_eq("rst_ovf", 32'(i0.overflow), 32'd0);
        check_eq("rst_drop", 32'(i0.drop_cnt), 32'd0);
        check_eq("rst_state", 32'(dut0.state_q), 32'(IDLE));

        // a0 0->5->5->9 with consumer always ready
        i0.en = 1'b1;
        tick();
        check_eq("run_state", 32'(dut0.state_q), 32'(RUN));
        i0.a0_in = 32'd5; i0.out_ready = 1'b1;
        tick();
        check_eq("e0_valid", 32'(i0.out_valid), 32'd1);
        check_eq("e0_data", i0.out_data, 32'd5);
        check_eq("e0_seq", 32'(i0.out_seq), 32'd0);
        tick();
        check_eq("nochg_valid", 32'(i0.out_valid), 32'd0);
        i0.a0_in = 32'd9;
        tick();
        check_eq("e1_valid", 32'(i0.out_valid), 32'd1);
        check_eq("e1_data", i0.out_data, 32'd9);
        check_eq("e1_seq", 32'(i0.out_seq), 32'd1);
        tick();
        check_eq("e1_popped", 32'(i0.out_valid), 32'd0);

        // Restart sequence, then overfill with 10 changes
        rst = 1'b1; i0.a0_in = '0; i0.out_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 1; i <= 10; i++) begin
            i0.a0_in = 32'(i);
            tick();
        end
        check_eq("ovr_level", 32'(i0.level), 32'd8);
        check_eq("ovr_ovf", 32'(i0.overflow), 32'd1);
        check_eq("ovr_drop", 32'(i0.drop_cnt), 32'd2);
        check_eq("ovr_head_seq", 32'(i0.out_seq), 32'd0);
        check_eq("ovr_head_data", i0.out_data, 32'd1);
        tick();
        check_eq("ovr_hold_seq", 32'(i0.out_seq), 32'd0);

        // Full FIFO: change coincident with a pop is accepted
        i0.a0_in = 32'd11; i0.out_ready = 1'b1;
        tick();
        check_eq("fp_level", 32'(i0.level), 32'd8);
        check_eq("fp_drop", 32'(i0.drop_cnt), 32'd2);
        for (int k = 1; k <= 8; k++) begin
            check_eq("drain_valid", 32'(i0.out_valid), 32'd1);
            check_eq("drain_seq", 32'(i0.out_seq), 32'(k));
            check_eq("drain_data", i0.out_data, (k < 8) ? 32'(k + 1) : 32'd11);
            tick();
        end
        check_eq("drain_empty", 32'(i0.out_valid), 32'd0);
        check_eq("drain_level", 32'(i0.level), 32'd0);
        check_eq("drain_ovf", 32'(i0.overflow), 32'd1);

        // clr, then 300 drops to saturate drop_cnt
        i0.clr = 1'b1;
        tick();
        i0.clr = 1'b0;
        check_eq("clr_ovf", 32'(i0.overflow), 32'd0);
        check_eq("clr_drop", 32'(i0.drop_cnt), 32'd0);
        check_eq("clr_state", 32'(dut0.state_q), 32'(IDLE));
        i0.out_ready = 1'b0;
        tick();
        for (int i = 0; i < 308; i++) begin
            i0.a0_in = 32'(100 + i);
            tick();
        end
        check_eq("sat_drop", 32'(i0.drop_cnt), 32'd255);
        check_eq("sat_ovf", 32'(i0.overflow), 32'd1);
        check_eq("sat_level", 32'(i0.level), 32'd8);
        tick(); tick();
        check_eq("sat_ovf_sticky", 32'(i0.overflow), 32'd1);
        i0.clr = 1'b1;
        tick();
        i0.clr = 1'b0;
        check_eq("sat_clr_ovf", 32'(i0.overflow), 32'd0);
        check_eq("sat_clr_drop", 32'(i0.drop_cnt), 32'd0);
        check_eq("sat_clr_level", 32'(i0.level), 32'd0);

        // Three entries queued, then reset mid-burst
        tick();
        for (int i = 201; i <= 203; i++) begin
            i0.a0_in = 32'(i);
            tick();
        end
        check_eq("q3_level", 32'(i0.level), 32'd3);
        rst = 1'b1; i0.out_ready = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mrst_valid", 32'(i0.out_valid), 32'd0);
        check_eq("mrst_level", 32'(i0.level), 32'd0);
        check_eq("mrst_data", i0.out_data, 32'd0);
        tick();
        i0.a0_in = 32'd204;
        tick();
        check_eq("mrst_cap_valid", 32'(i0.out_valid), 32'd1);
        check_eq("mrst_cap_seq", 32'(i0.out_seq), 32'd0);
        check_eq("mrst_cap_data", i0.out_data, 32'd204);

        // Stop-on-full instance: overfill by one -> HALT
        i1.en = 1'b1;
        tick();
        for (int i = 1; i <= 9; i++) begin
            i1.a0_in = 32'(i);
            tick();
        end
        check_eq("sof_state", 32'(dut1.state_q), 32'(HALT));
        check_eq("sof_drop", 32'(i1.drop_cnt), 32'd1);
        check_eq("sof_level", 32'(i1.level), 32'd8);
        i1.a0_in = 32'd10;
        tick();
        i1.a0_in = 32'd11;
        tick();
        check_eq("halt_drop", 32'(i1.drop_cnt), 32'd1);
        check_eq("halt_state", 32'(dut1.state_q), 32'(HALT));
        i1.clr = 1'b1;
        tick();
        i1.clr = 1'b0;
        check_eq("hclr_level", 32'(i1.level), 32'd0);
        check_eq("hclr_state", 32'(dut1.state_q), 32'(IDLE));
        check_eq("hclr_drop", 32'(i1.drop_cnt), 32'd0);
        tick();
        i1.a0_in = 32'd12;
        tick();
        check_eq("resume_valid", 32'(i1.out_valid), 32'd1);
        check_eq("resume_seq", 32'(i1.out_seq), 32'd8);
        check_eq("resume_data", i1.out_data, 32'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
